// File: rtl/set_job_sequencer.sv
// set_job_sequencer: FIFO-buffered job issuer for the SET candidate counter,
// returning each tagged result over a valid/ready port with a saturating total.
module set_job_sequencer #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [7:0]               req_central,
    input  logic [3:0]               req_radius,
    output logic                     req_ready,
    output logic                     set_en,
    output logic [7:0]               set_central,
    output logic [3:0]               set_radius,
    input  logic                     set_busy,
    input  logic                     set_valid,
    input  logic [7:0]               set_candidate,
    output logic                     res_valid,
    output logic [7:0]               res_candidate,
    output logic [IDX_W-1:0]         res_index,
    input  logic                     res_ready,
    output logic [15:0]              total,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     proto_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t            state_q, state_d;
    logic [11:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic [7:0]        cen_q, cand_q;
    logic [3:0]        rad_q;
    logic [IDX_W-1:0]  idx_q;
    logic [15:0]       tot_q;
    logic              err_q, settle_q;
    logic              push, pop, done;
    logic [16:0]       sum;

    assign req_ready = cnt_q != (AW+1)'(DEPTH);
    assign push = req_valid && req_ready;
    assign pop = (state_q == IDLE) && (state_d == ISSUE);
    assign done = (state_q == HOLD) && res_ready;
    assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    assign sum = {1'b0, tot_q} + {9'd0, cand_q};

    // settle_q holds IDLE for one cycle after a result handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cnt_q != '0 && !set_busy && !settle_q) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (set_valid) state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {req_central, req_radius};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            cen_q    <= '0;
            rad_q    <= '0;
            cand_q   <= '0;
            idx_q    <= '0;
            tot_q    <= '0;
            err_q    <= 1'b0;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= done;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                {cen_q, rad_q} <= mem_q[rd_q];
                rd_q <= rd_q + 1'b1;
            end
            if (state_q == WAIT && set_valid) cand_q <= set_candidate;
            if (done) begin
                idx_q <= idx_q + 1'b1;
                tot_q <= sum[16] ? 16'hFFFF : sum[15:0];
            end
            if (set_valid && state_q != WAIT) err_q <= 1'b1;
        end
    end

    assign set_en        = state_q == ISSUE;
    assign res_valid     = state_q == HOLD;
    assign set_central   = cen_q;
    assign set_radius    = rad_q;
    assign res_candidate = cand_q;
    assign res_index     = idx_q;
    assign total         = tot_q;
    assign fifo_level    = cnt_q;
    assign proto_err     = err_q;
endmodule

// File: tb/tb_set_job_sequencer.sv
// tb_set_job_sequencer: directed vectors and corner sequences for set_job_sequencer.
module tb_set_job_sequencer;
    logic        clk, rst, req_valid, req_ready, set_en, set_busy, set_valid;
    logic        res_valid, res_ready, proto_err;
    logic [7:0]  req_central, set_central, set_candidate, res_candidate;
    logic [3:0]  req_radius, set_radius;
    logic [5:0]  res_index;
    logic [15:0] total;
    logic [2:0]  fifo_level;
    int          nchk = 0, nerr = 0, en_cnt = 0, e0;
    logic [5:0]  exp_idx;
    logic [15:0] exp_total;

    typedef struct {
        logic [7:0]  c;
        logic [3:0]  r;
        logic [7:0]  cand;
        logic [5:0]  idx;
        logic [15:0] tot;
    } vec_t;
    vec_t vt[4];

    set_job_sequencer #(.DEPTH(4), .IDX_W(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_central(req_central), .req_radius(req_radius),
        .req_ready(req_ready),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
        .res_valid(res_valid), .res_candidate(res_candidate), .res_index(res_index),
        .res_ready(res_ready), .total(total), .fifo_level(fifo_level),
        .proto_err(proto_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (!rst && set_en) en_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", nchk, nerr);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; req_valid = 0; set_busy = 0; set_valid = 0; res_ready = 0;
        set_candidate = 0; req_central = 0; req_radius = 0;
        tick(); tick();
        rst = 0;
        exp_total = 0; exp_idx = 0;
    endtask

    task automatic push_job(input logic [7:0] c, input logic [3:0] r);
        int n = 0;
        req_valid = 1; req_central = c; req_radius = r;
        while (!req_ready && n < 200) begin tick(); n++; end
        chk("push_ready", {31'd0, req_ready}, 1);
        tick();
        req_valid = 0;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!set_en && n < 100) begin tick(); n++; end
        chk("set_en_seen", {31'd0, set_en}, 1);
    endtask

    task automatic serve(input logic [7:0] cand);
        tick();
        chk("set_en_one_cycle", {31'd0, set_en}, 0);
        tick();
        chk("res_valid_pre", {31'd0, res_valid}, 0);
        set_valid = 1; set_candidate = cand;
        tick();
        set_valid = 0;
        chk("res_valid_capture", {31'd0, res_valid}, 1);
        chk("res_candidate", {24'd0, res_candidate}, {24'd0, cand});
        chk("res_index", {26'd0, res_index}, {26'd0, exp_idx});
    endtask

    task automatic accept(input logic [7:0] cand);
        logic [16:0] s;
        s = {1'b0, exp_total} + {9'd0, cand};
        exp_total = s[16] ? 16'hFFFF : s[15:0];
        exp_idx = exp_idx + 1'b1;
        res_ready = 1;
        tick();
        res_ready = 0;
        chk("res_valid_after_hs", {31'd0, res_valid}, 0);
        chk("res_index_after_hs", {26'd0, res_index}, {26'd0, exp_idx});
        chk("total_after_hs", {16'd0, total}, {16'd0, exp_total});
        chk("set_en_r1", {31'd0, set_en}, 0);
        tick();
        chk("set_en_r2", {31'd0, set_en}, 0);
    endtask

    task automatic run_job(input logic [7:0] c, input logic [3:0] r, input logic [7:0] cand);
        push_job(c, r);
        chk("issue_early", {31'd0, set_en}, 0);
        tick();
        chk("issue_latency", {31'd0, set_en}, 1);
        chk("set_central", {24'd0, set_central}, {24'd0, c});
        chk("set_radius", {28'd0, set_radius}, {28'd0, r});
        serve(cand);
        accept(cand);
    endtask

    initial begin
        vt[0] = '{8'h44, 4'd3,  8'd29,  6'd0, 16'd29};
        vt[1] = '{8'h12, 4'd5,  8'd7,   6'd1, 16'd36};
        vt[2] = '{8'hA7, 4'd0,  8'd0,   6'd2, 16'd36};
        vt[3] = '{8'hFF, 4'd15, 8'd200, 6'd3, 16'd236};

        do_reset();
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_set_en", {31'd0, set_en}, 0);
        chk("rst_set_central", {24'd0, set_central}, 0);
        chk("rst_set_radius", {28'd0, set_radius}, 0);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_res_candidate", {24'd0, res_candidate}, 0);
        chk("rst_res_index", {26'd0, res_index}, 0);
        chk("rst_total", {16'd0, total}, 0);
        chk("rst_fifo_level", {29'd0, fifo_level}, 0);
        chk("rst_proto_err", {31'd0, proto_err}, 0);

        // Table-driven single jobs
        for (int i = 0; i < 4; i++) begin
            e0 = en_cnt;
            push_job(vt[i].c, vt[i].r);
            chk("vec_issue_early", {31'd0, set_en}, 0);
            tick();
            chk("vec_issue", {31'd0, set_en}, 1);
            chk("vec_central", {24'd0, set_central}, {24'd0, vt[i].c});
            chk("vec_radius", {28'd0, set_radius}, {28'd0, vt[i].r});
            serve(vt[i].cand);
            chk("vec_index", {26'd0, res_index}, {26'd0, vt[i].idx});
            accept(vt[i].cand);
            chk("vec_total", {16'd0, total}, {16'd0, vt[i].tot});
            chk("vec_one_pulse", en_cnt - e0, 1);
        end
        chk("proto_err_clean", {31'd0, proto_err}, 0);

        // Backpressure and full FIFO
        do_reset();
        e0 = en_cnt;
        for (int k = 0; k < 5; k++) push_job(8'h10 + 8'(k), 4'(k));
        chk("bp_level_full", {29'd0, fifo_level}, 4);
        chk("bp_ready_low", {31'd0, req_ready}, 0);
        chk("bp_one_issue", en_cnt - e0, 1);
        chk("bp_first_central", {24'd0, set_central}, 32'h10);
        set_valid = 1; set_candidate = 8'd50;
        tick();
        set_valid = 0;
        chk("bp_res_valid", {31'd0, res_valid}, 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_hold_valid", {31'd0, res_valid}, 1);
            chk("bp_hold_cand", {24'd0, res_candidate}, 50);
            chk("bp_hold_no_en", {31'd0, set_en}, 0);
        end
        chk("bp_hold_index", {26'd0, res_index}, 0);
        accept(8'd50);
        chk("bp_full_pop_ready", {31'd0, req_ready}, 0);
        for (int k = 1; k < 5; k++) begin
            wait_en();
            if (k == 1) begin
                chk("bp_level_after_pop", {29'd0, fifo_level}, 3);
                chk("bp_ready_after_pop", {31'd0, req_ready}, 1);
            end
            chk("bp_central", {24'd0, set_central}, 32'h10 + 32'(k));
            chk("bp_radius", {28'd0, set_radius}, 32'(k));
            serve(8'd50 + 8'(k));
            accept(8'd50 + 8'(k));
        end
        chk("bp_total", {16'd0, total}, 260);

        // Index wrap and saturation
        do_reset();
        for (int k = 0; k < 260; k++) begin
            run_job(8'h55, 4'd2, 8'd255);
            if (k == 63) chk("wrap_index_0", {26'd0, res_index}, 0);
            if (k == 64) chk("wrap_index_1", {26'd0, res_index}, 1);
            if (k == 255) chk("sat_pre", {16'd0, total}, 65280);
            if (k == 256) chk("sat_reach", {16'd0, total}, 32'hFFFF);
        end
        chk("sat_hold", {16'd0, total}, 32'hFFFF);

        // Busy stall
        do_reset();
        e0 = en_cnt;
        set_busy = 1;
        push_job(8'h21, 4'd1);
        push_job(8'h22, 4'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("busy_no_en", {31'd0, set_en}, 0);
        end
        chk("busy_no_issue", en_cnt - e0, 0);
        chk("busy_level", {29'd0, fifo_level}, 2);
        set_busy = 0;
        tick();
        chk("busy_release_en", {31'd0, set_en}, 1);
        chk("busy_central", {24'd0, set_central}, 32'h21);
        serve(8'd5);
        accept(8'd5);
        wait_en();
        chk("busy_central2", {24'd0, set_central}, 32'h22);
        serve(8'd6);
        accept(8'd6);

        // Reset mid-job
        do_reset();
        run_job(8'h30, 4'd4, 8'd17);
        e0 = en_cnt;
        push_job(8'h31, 4'd1);
        push_job(8'h32, 4'd2);
        push_job(8'h33, 4'd3);
        chk("mid_level", {29'd0, fifo_level}, 2);
        chk("mid_issued", en_cnt - e0, 1);
        rst = 1;
        tick();
        chk("mid_level_rst", {29'd0, fifo_level}, 0);
        chk("mid_res_valid", {31'd0, res_valid}, 0);
        chk("mid_total", {16'd0, total}, 0);
        chk("mid_index", {26'd0, res_index}, 0);
        chk("mid_central", {24'd0, set_central}, 0);
        rst = 0; exp_total = 0; exp_idx = 0;
        e0 = en_cnt;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("mid_no_result", {31'd0, res_valid}, 0);
        end
        chk("mid_no_issue", en_cnt - e0, 0);
        run_job(8'h34, 4'd6, 8'd9);
        chk("mid_after_total", {16'd0, total}, 9);

        // Spurious valid in IDLE
        chk("spur_pre", {31'd0, proto_err}, 0);
        set_valid = 1; set_candidate = 8'd99;
        tick();
        set_valid = 0;
        chk("spur_err", {31'd0, proto_err}, 1);
        chk("spur_res_valid", {31'd0, res_valid}, 0);
        chk("spur_cand", {24'd0, res_candidate}, 9);
        run_job(8'h66, 4'd7, 8'd40);
        chk("spur_sticky", {31'd0, proto_err}, 1);
        chk("spur_total", {16'd0, total}, 49);
        do_reset();
        chk("spur_cleared", {31'd0, proto_err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
